// File: rtl/meas_display_pkg.sv
// Shared definitions for meas_display: FSM state codes, segment constants,
// clamp default and the double-dabble digit correction helper.
package meas_display_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    DISP_IDLE    = 2'd0,
    DISP_CONVERT = 2'd1,
    DISP_LATCH   = 2'd2
  } disp_state_e;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_A     = 7'h08;

  // Largest value the four-digit display can show
  localparam int CLAMP_MAX_DEFAULT = 9999;

  // Binary width of the selected value and number of shift iterations
  localparam int BIN_W      = 14;
  localparam int BCD_DIGITS = 4;
  localparam logic [3:0] LAST_ITER = 4'd13;

  // Double-dabble correction: a digit of 5 or more would overflow past 9
  // after the next doubling, so pre-add 3 to carry into the next digit.
  function automatic logic [3:0] bcd_adjust(input logic [3:0] i_digit);
    return (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;
  endfunction

endpackage

// File: rtl/meas_display_seg7_encoder.sv
// seg7_encoder: one BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Code 10 renders 'A'; other non-decimal codes render blank.
import meas_display_pkg::*;

module seg7_encoder (
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Pure lookup; the caller registers the result
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = 7'h40;
      4'd1:    o_seg = 7'h79;
      4'd2:    o_seg = 7'h24;
      4'd3:    o_seg = 7'h30;
      4'd4:    o_seg = 7'h19;
      4'd5:    o_seg = 7'h12;
      4'd6:    o_seg = 7'h02;
      4'd7:    o_seg = 7'h78;
      4'd8:    o_seg = 7'h00;
      4'd9:    o_seg = 7'h10;
      4'd10:   o_seg = SEG_A;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/meas_display.sv
// meas_display: captures a live or averaged millivolt value, clamps it,
// converts it to BCD by serial double dabble (14 cycles) and drives four
// registered 7-segment digits plus an 'A' average indicator on HEX5.
// One refresh every 16 cycles: IDLE (capture), 14x CONVERT, LATCH.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zeros on HEX3..HEX1.
import meas_display_pkg::*;

module meas_display #(
  parameter int CLAMP_MAX = CLAMP_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] meas_value,
  input  logic [13:0] acumul_value,
  input  logic        average_enable,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX5,
  output logic        busy,
  output logic        update_tick
);

  localparam logic [BIN_W-1:0] CLAMP_LIM = BIN_W'(CLAMP_MAX);
  localparam int SHIFT_W = BIN_W + 4 * BCD_DIGITS;

  disp_state_e          r_state;
  // {bcd digits [29:14], binary operand [13:0]}
  logic [SHIFT_W-1:0]   r_shift;
  logic [3:0]           r_iter;
  logic                 r_mode;

  logic [BIN_W-1:0]     w_sel;
  logic [BIN_W-1:0]     w_clamped;
  logic [SHIFT_W-1:0]   w_adjusted;
  logic [3:0]           w_digit [BCD_DIGITS];
  logic [6:0]           w_seg   [BCD_DIGITS];
  logic [6:0]           w_hex   [BCD_DIGITS];

  // Source select and clamp to the displayable range
  always_comb begin
    w_sel     = average_enable ? acumul_value : {2'b00, meas_value};
    w_clamped = (w_sel > CLAMP_LIM) ? CLAMP_LIM : w_sel;
  end

  // Per-digit correction and encoding; the binary part passes through unchanged
  assign w_adjusted[BIN_W-1:0] = r_shift[BIN_W-1:0];
  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
      assign w_digit[gi] = r_shift[BIN_W + 4*gi +: 4];
      assign w_adjusted[BIN_W + 4*gi +: 4] = bcd_adjust(w_digit[gi]);
      seg7_encoder u_enc (
        .i_digit (w_digit[gi]),
        .o_seg   (w_seg[gi])
      );
    end
  endgenerate

  // Leading-zero handling on the three upper digits; units always shown
  always_comb begin
    for (int i = 0; i < BCD_DIGITS; i++) w_hex[i] = w_seg[i];
`ifdef LEADING_ZERO_BLANK_EN
    if (w_digit[3] == 4'd0) begin
      w_hex[3] = SEG_BLANK;
      if (w_digit[2] == 4'd0) begin
        w_hex[2] = SEG_BLANK;
        if (w_digit[1] == 4'd0) w_hex[1] = SEG_BLANK;
      end
    end
`endif
  end

  // Capture / convert / latch sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= DISP_IDLE;
      r_shift     <= '0;
      r_iter      <= 4'd0;
      r_mode      <= 1'b0;
      HEX0        <= SEG_BLANK;
      HEX1        <= SEG_BLANK;
      HEX2        <= SEG_BLANK;
      HEX3        <= SEG_BLANK;
      HEX5        <= SEG_BLANK;
      busy        <= 1'b0;
      update_tick <= 1'b0;
    end else begin
      update_tick <= 1'b0;
      case (r_state)
        DISP_IDLE: begin
          r_shift <= {{(4*BCD_DIGITS){1'b0}}, w_clamped};
          r_mode  <= average_enable;
          r_iter  <= 4'd0;
          busy    <= 1'b1;
          r_state <= DISP_CONVERT;
        end
        DISP_CONVERT: begin
          r_shift <= w_adjusted << 1;
          r_iter  <= r_iter + 4'd1;
          if (r_iter == LAST_ITER) r_state <= DISP_LATCH;
        end
        DISP_LATCH: begin
          HEX0        <= w_hex[0];
          HEX1        <= w_hex[1];
          HEX2        <= w_hex[2];
          HEX3        <= w_hex[3];
          HEX5        <= r_mode ? SEG_A : SEG_BLANK;
          update_tick <= 1'b1;
          busy        <= 1'b0;
          r_state     <= DISP_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= DISP_IDLE;
        end
      endcase
    end
  end

endmodule
